// File: rtl/pheap_root.sv
// rtl/pheap_root.sv - root stage of a pipelined max-priority heap
package pheap_pkg;
    localparam int KEY_W = 8;
    localparam int VAL_W = 8;

    typedef enum logic [1:0] {
        OP_LEQ     = 2'd0,
        OP_DEQ     = 2'd1,
        OP_ENQ_DEQ = 2'd2
    } opcode_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    typedef struct packed {
        logic active;
        kv_t  kv;
    } entry_t;

    localparam kv_t    KV_EMPTY    = '0;
    localparam entry_t ENTRY_EMPTY = '0;
endpackage

module pheap_root
    import pheap_pkg::*;
#(
    parameter int LEVELS = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    input  opcode_t           req_op,
    input  kv_t               req_kv,
    output logic              req_ready,

    output logic              rsp_valid,
    output kv_t               rsp_kv,
    output logic              rsp_err,

    output logic [LEVELS-1:0] count,
    output logic              full,
    output logic              empty,

    output logic              l2_ren,
    input  entry_t            rBotL,
    input  entry_t            rBotR,

    output logic              l2_start,
    output opcode_t           l2_op,
    output logic              l2_startPos,
    output kv_t               l2_in,
    input  logic              l2_active
);

    localparam int CAP = 2**LEVELS - 1;
    localparam int CW  = LEVELS - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t        state, state_nxt;
    entry_t        root, root_nxt;
    logic [CW-1:0] lcnt, lcnt_nxt;
    logic [CW-1:0] rcnt, rcnt_nxt;
    opcode_t       op_q;
    kv_t           kv_q;

    logic accept;
    logic pick_right;
    logic ins_right;
    logic req_gt_l;
    logic req_gt_r;

    assign req_ready = (state == IDLE) && !l2_active && !rst;
    assign accept    = req_valid && req_ready;
    assign l2_ren    = (state == READ) && !rst;

    assign count = LEVELS'(root.active) + LEVELS'(lcnt) + LEVELS'(rcnt);
    assign full  = (count == LEVELS'(CAP));
    assign empty = (count == '0);

    // Inactive entries lose every comparison; ties favour the left child.
    assign pick_right = rBotR.active && (!rBotL.active || (rBotR.kv.key > rBotL.kv.key));
    assign ins_right  = (lcnt > rcnt);
    assign req_gt_l   = !rBotL.active || (kv_q.key > rBotL.kv.key);
    assign req_gt_r   = !rBotR.active || (kv_q.key > rBotR.kv.key);

    always_comb begin
        state_nxt   = state;
        root_nxt    = root;
        lcnt_nxt    = lcnt;
        rcnt_nxt    = rcnt;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_kv      = KV_EMPTY;
        l2_start    = 1'b0;
        l2_op       = OP_LEQ;
        l2_startPos = 1'b0;
        l2_in       = KV_EMPTY;

        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state == EXEC && !rst) begin
            case (op_q)
                OP_LEQ: begin
                    if (empty) begin
                        root_nxt = {1'b1, kv_q};
                    end else if (full) begin
                        rsp_valid = 1'b1;
                        rsp_err   = 1'b1;
                    end else begin
                        // The loser of root vs. new entry sinks into the lighter subtree.
                        l2_start    = 1'b1;
                        l2_op       = OP_LEQ;
                        l2_startPos = ins_right;
                        if (root.kv.key >= kv_q.key) begin
                            l2_in = kv_q;
                        end else begin
                            l2_in    = root.kv;
                            root_nxt = {1'b1, kv_q};
                        end
                        if (ins_right) rcnt_nxt = rcnt + CW'(1);
                        else           lcnt_nxt = lcnt + CW'(1);
                    end
                end

                OP_DEQ: begin
                    rsp_valid = 1'b1;
                    if (empty) begin
                        rsp_err = 1'b1;
                    end else begin
                        rsp_kv = root.kv;
                        if (!rBotL.active && !rBotR.active) begin
                            root_nxt = ENTRY_EMPTY;
                        end else begin
                            root_nxt    = pick_right ? rBotR : rBotL;
                            l2_start    = 1'b1;
                            l2_op       = OP_DEQ;
                            l2_startPos = pick_right;
                            if (pick_right) rcnt_nxt = rcnt - CW'(1);
                            else            lcnt_nxt = lcnt - CW'(1);
                        end
                    end
                end

                OP_ENQ_DEQ: begin
                    rsp_valid = 1'b1;
                    if (empty) begin
                        root_nxt = {1'b1, kv_q};
                    end else begin
                        rsp_kv = root.kv;
                        if (req_gt_l && req_gt_r) begin
                            root_nxt = {1'b1, kv_q};
                        end else begin
                            // Promote the larger child; the new entry replaces it one level down.
                            root_nxt    = pick_right ? rBotR : rBotL;
                            l2_start    = 1'b1;
                            l2_op       = OP_ENQ_DEQ;
                            l2_startPos = pick_right;
                            l2_in       = kv_q;
                        end
                    end
                end

                default: begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            root  <= ENTRY_EMPTY;
            lcnt  <= '0;
            rcnt  <= '0;
            op_q  <= OP_LEQ;
            kv_q  <= KV_EMPTY;
        end else begin
            state <= state_nxt;
            root  <= root_nxt;
            lcnt  <= lcnt_nxt;
            rcnt  <= rcnt_nxt;
            if (accept) begin
                op_q <= req_op;
                kv_q <= req_kv;
            end
        end
    end

endmodule

// File: doc/pheap_root.md
PHEAP_ROOT -- requirements
Module: pheap_root

Interface
REQ-001 The module SHALL have parameter LEVELS, default 4, giving the total heap levels including the root (LEVELS >= 2); capacity CAP = 2^LEVELS - 1.
REQ-002 The module SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 The module SHALL have ports: req_valid  in  1  request present; req_op  in  opcode_t  LEQ/DEQ/ENQ_DEQ; req_kv  in  kv_t  key/value to insert; req_ready  out  1  request accepted when high with req_valid.
REQ-004 The module SHALL have ports: rsp_valid  out  1  one-cycle response pulse; rsp_kv  out  kv_t  removed entry; rsp_err  out  1  error qualifier on rsp_valid.
REQ-005 The module SHALL have ports: count  out  LEVELS  occupancy; full  out  1  count==CAP; empty  out  1  count==0.
REQ-006 The module SHALL have ports: l2_ren  out  1  read level-2 entries 0 and 1; rBotL, rBotR  in  entry_t  level-2 entries, valid the cycle after l2_ren.
REQ-007 The module SHALL have ports: l2_start  out  1  launch pulse to level 2; l2_op  out  opcode_t; l2_startPos  out  1  child index; l2_in  out  kv_t; l2_active  in  1  level-2 busy.

Function
REQ-008 The heap SHALL be a max-heap: each parent key >= its child keys; inactive entries compare less than every active entry.
REQ-009 The root entry SHALL be held in an internal entry_t register.
REQ-010 The FSM SHALL have states IDLE, READ, EXEC: IDLE->READ on accept, READ->EXEC always, EXEC->IDLE always.
REQ-011 req_ready SHALL equal (state==IDLE && !l2_active && !rst); acceptance latches req_op/req_kv.
REQ-012 l2_ren SHALL be high exactly in READ; all decisions SHALL be made combinationally in EXEC from the root, rBotL, rBotR; results register at the end of EXEC.
REQ-013 rsp_valid SHALL pulse in EXEC (accept cycle +2) for DEQ and ENQ_DEQ, never for LEQ except error.
REQ-014 l2_start SHALL pulse at most once per request, only in EXEC, together with l2_op/l2_startPos/l2_in.
REQ-015 Internal counters lcnt, rcnt (LEVELS-1 bits each) SHALL track occupancy of the left and right subtrees; count = root.active + lcnt + rcnt.
REQ-016 LEQ, empty: root <= req_kv, active; no launch.
REQ-017 LEQ, not full and root active: the larger of root and req_kv stays as root (root retained on equal keys); the smaller is launched with op LEQ to child 0 if lcnt <= rcnt, else child 1; that counter increments.
REQ-018 LEQ, full: no state change, no launch, rsp_valid=1, rsp_err=1, rsp_kv=KV_EMPTY.
REQ-019 DEQ, empty: rsp_valid=1, rsp_err=1, rsp_kv=KV_EMPTY, no launch.
REQ-020 DEQ, non-empty: rsp_kv = root.kv; if neither child is active, root becomes inactive; otherwise root <= larger active child (left on equal keys), DEQ is launched at that child index, and that counter decrements.
REQ-021 ENQ_DEQ, non-empty: rsp_kv = root.kv; if req_kv > both children, root <= req_kv with no launch; else root <= larger child (left on tie), ENQ_DEQ is launched at that index with l2_in = req_kv; counts are unchanged.
REQ-022 ENQ_DEQ, empty: treated as LEQ into an empty root with rsp_valid=1, rsp_kv=KV_EMPTY, rsp_err=0.
REQ-023 Spacing: after a launch, l2_active gates req_ready until level 2 has written its memory, so READ never coincides with a level-2 write.
REQ-024 When not asserted, l2_op SHALL be LEQ, l2_in SHALL be KV_EMPTY, l2_startPos SHALL be 0, and rsp_kv SHALL be KV_EMPTY.

Reset
REQ-025 When rst is high, the next state SHALL be IDLE, the root SHALL be inactive (ENTRY_EMPTY), lcnt=rcnt=0, and rsp_valid, rsp_err, l2_start, l2_ren, req_ready SHALL be 0; count=0, empty=1, full=0.
REQ-026 A reset in READ or EXEC SHALL discard the captured request: no rsp_valid, no l2_start, no counter change.

Verification (LEVELS=3, CAP=7)
REQ-027 rst, then LEQ key 5 -> rsp_valid stays 0, l2_start stays 0, count=1, root key 5.
REQ-028 Then LEQ 9, then LEQ 3 -> first: l2_start at accept+2 with op LEQ, startPos 0, l2_in key 5, root 9; second: startPos 1, l2_in key 3; count=3.
REQ-029 DEQ with rBotL key 5 and rBotR key 3 -> rsp_valid at accept+2 with rsp_kv key 9; l2_start DEQ at startPos 0; root key 5; count=2.
REQ-030 DEQ after reset -> rsp_valid=1, rsp_err=1, rsp_kv=KV_EMPTY, no l2_start; LEQ at count=7 -> rsp_err=1, count stays 7.
REQ-031 ENQ_DEQ key 4 with root key 8 and children 6 and 2 -> rsp_kv key 8, root key 6, l2_start ENQ_DEQ at startPos 0 with l2_in key 4.
REQ-032 With l2_active held high for 3 cycles, req_ready stays 0 and the request is accepted the first cycle l2_active is low; rst asserted in READ -> no rsp_valid, count unchanged.
